// File: rtl/wm_fill_level_monitor.sv
// rtl/wm_fill_level_monitor.sv - water fill level monitor and inlet valve control
//
// Purpose: filters the raw level sensor and drives the inlet valve while the
// controller requests water. It qualifies "full" with settle time and hysteresis,
// and raises timeout/overflow faults that are held until the request drops.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_tick                one-cycle sample/time-base enable
//   i_fill_req            fill request (controller water_pump_on), level-sensitive
//   i_water_level_select  target select, latched on IDLE->FILLING only
//   i_level_sensor        raw level sample
//   o_inlet_valve_on      valve drive
//   o_water_full          level qualified as full
//   o_fill_fault          fault flag, held until fill request drops
//   o_fault_code          00 none, 01 timeout, 10 overflow
//   o_level_filtered      4-sample moving average of the sensor
//   o_state_dbg           FSM state encoding
module wm_fill_level_monitor #(
  parameter int LVL_W        = 8,
  parameter int LOW_TARGET   = 64,
  parameter int MED_TARGET   = 128,
  parameter int HIGH_TARGET  = 192,
  parameter int HYST         = 8,
  parameter int OVERFLOW_LVL = 240,
  parameter int SETTLE_TICKS = 4,
  parameter int FILL_TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_fill_req,
  input  logic [1:0]       i_water_level_select,
  input  logic [LVL_W-1:0] i_level_sensor,
  output logic             o_inlet_valve_on,
  output logic             o_water_full,
  output logic             o_fill_fault,
  output logic [1:0]       o_fault_code,
  output logic [LVL_W-1:0] o_level_filtered,
  output logic [2:0]       o_state_dbg
);

  localparam int TCNT_W = $clog2(FILL_TIMEOUT + 1);
  localparam int SCNT_W = $clog2(SETTLE_TICKS + 1);

  localparam logic [LVL_W-1:0]  L_LOW      = LVL_W'(LOW_TARGET);
  localparam logic [LVL_W-1:0]  L_MED      = LVL_W'(MED_TARGET);
  localparam logic [LVL_W-1:0]  L_HIGH     = LVL_W'(HIGH_TARGET);
  localparam logic [LVL_W-1:0]  L_HYST     = LVL_W'(HYST);
  localparam logic [LVL_W-1:0]  L_OVERFLOW = LVL_W'(OVERFLOW_LVL);
  localparam logic [TCNT_W-1:0] L_TIMEOUT  = TCNT_W'(FILL_TIMEOUT);
  localparam logic [SCNT_W-1:0] L_SETTLE   = SCNT_W'(SETTLE_TICKS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILLING = 3'd1,
    S_SETTLE  = 3'd2,
    S_FULL    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t            r_state, w_next_state;
  logic [LVL_W-1:0]  r_tap0, r_tap1, r_tap2;
  logic [LVL_W-1:0]  r_filtered, r_target, r_thr_lo;
  logic [TCNT_W-1:0] r_tcnt, w_tcnt_next, w_tcnt_inc;
  logic [SCNT_W-1:0] r_scnt, w_scnt_next, w_scnt_inc;
  logic [1:0]        r_fault_code, w_fault_code_next;
  logic              w_latch_target, w_overflow;
  logic [LVL_W+1:0]  w_sum;
  logic [LVL_W-1:0]  w_sel_target;

  // The incoming sample acts as the newest of the four taps, so the average
  // registered on the tick edge already includes it (visible one cycle later).
  assign w_sum = {2'b00, i_level_sensor} + {2'b00, r_tap0}
               + {2'b00, r_tap1} + {2'b00, r_tap2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tap0     <= '0;
      r_tap1     <= '0;
      r_tap2     <= '0;
      r_filtered <= '0;
    end else if (i_tick) begin
      r_tap0     <= i_level_sensor;
      r_tap1     <= r_tap0;
      r_tap2     <= r_tap1;
      r_filtered <= w_sum[LVL_W+1:2];
    end
  end

  // Reserved select value 11 falls back to the medium target.
  always_comb begin
    w_sel_target = L_MED;
    case (i_water_level_select)
      2'b00:   w_sel_target = L_LOW;
      2'b10:   w_sel_target = L_HIGH;
      default: w_sel_target = L_MED;
    endcase
  end

  assign w_overflow = (r_filtered >= L_OVERFLOW);
  assign w_tcnt_inc = r_tcnt + TCNT_W'(1);
  assign w_scnt_inc = r_scnt + SCNT_W'(1);

  // Priority: overflow, then request drop (outside FAULT), then per-state rules.
  always_comb begin
    w_next_state      = r_state;
    w_tcnt_next       = r_tcnt;
    w_scnt_next       = r_scnt;
    w_fault_code_next = r_fault_code;
    w_latch_target    = 1'b0;
    if (w_overflow) begin
      w_next_state      = S_FAULT;
      w_fault_code_next = 2'b10;
    end else if (!i_fill_req && (r_state != S_FAULT)) begin
      w_next_state = S_IDLE;
      w_tcnt_next  = '0;
      w_scnt_next  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_tcnt_next    = '0;
          w_next_state   = S_FILLING;
          w_latch_target = 1'b1;
        end
        S_FILLING: begin
          if (i_tick) w_tcnt_next = w_tcnt_inc;
          if (r_filtered >= r_target) begin
            w_next_state = S_SETTLE;
            w_scnt_next  = '0;
          end else if (i_tick && (w_tcnt_inc >= L_TIMEOUT)) begin
            w_next_state      = S_FAULT;
            w_fault_code_next = 2'b01;
          end
        end
        S_SETTLE: begin
          if (i_tick) begin
            if (r_filtered < r_thr_lo) begin
              w_next_state = S_FILLING;
              w_scnt_next  = '0;
            end else begin
              w_scnt_next = w_scnt_inc;
              if (w_scnt_inc >= L_SETTLE) w_next_state = S_FULL;
            end
          end
        end
        S_FULL: begin
          // Top-up: the timeout count resumes from its held value.
          if (r_filtered < r_thr_lo) w_next_state = S_FILLING;
        end
        S_FAULT: begin
          if (!i_fill_req) begin
            w_next_state      = S_IDLE;
            w_fault_code_next = 2'b00;
            w_tcnt_next       = '0;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcnt       <= '0;
      r_scnt       <= '0;
      r_fault_code <= 2'b00;
      r_target     <= '0;
      r_thr_lo     <= '0;
    end else begin
      r_tcnt       <= w_tcnt_next;
      r_scnt       <= w_scnt_next;
      r_fault_code <= w_fault_code_next;
      if (w_latch_target) begin
        r_target <= w_sel_target;
        r_thr_lo <= w_sel_target - L_HYST;
      end
    end
  end

  assign o_inlet_valve_on = (r_state == S_FILLING);
  assign o_water_full     = (r_state == S_FULL);
  assign o_fill_fault     = (r_state == S_FAULT);
  assign o_fault_code     = r_fault_code;
  assign o_level_filtered = r_filtered;
  assign o_state_dbg      = r_state;

endmodule

// File: doc/wm_fill_level_monitor.md
Name: wm_fill_level_monitor

Overview:
- Sits directly upstream of the washing machine controller.
- Takes the controller's water_pump_on as a fill request and drives the inlet valve.
- Filters the raw water-level (pressure) sensor and generates the controller's water_full input, with hysteresis, settle qualification and fault detection.
- Flags timeout and overflow faults for the controller's alarm path.

Parameters:
- LVL_W, 8, sensor/level width in bits
- LOW_TARGET, 64, full threshold for water_level_select=00
- MED_TARGET, 128, full threshold for select=01 and for reserved value 11
- HIGH_TARGET, 192, full threshold for select=10
- HYST, 8, hysteresis below target for dropout/top-up
- OVERFLOW_LVL, 240, filtered level at or above which overflow fault fires
- SETTLE_TICKS, 4, consecutive ticks at/above target before water_full
- FILL_TIMEOUT, 200, max ticks spent in FILLING per request

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  single-cycle sample/time-base enable
- fill_req  in  1  from controller water_pump_on; level-sensitive
- water_level_select  in  2  level selection; sampled only on IDLE->FILLING
- level_sensor  in  LVL_W  raw level sample
- inlet_valve_on  out  1  valve drive
- water_full  out  1  to controller water_full
- fill_fault  out  1  sticky fault flag
- fault_code  out  2  00 none, 01 timeout, 10 overflow
- level_filtered  out  LVL_W  filtered level
- state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset: all outputs are 0. FSM in IDLE. Filter taps, counters and latched target are 0.

Filter:
- On tick, shift level_sensor into a 4-tap register.
- level_filtered = (t0+t1+t2+t3)>>2, computed with an LVL_W+2-bit sum and registered.
- Update latency is 1 cycle after the tick cycle. After reset, taps are 0, so 4 ticks are needed to reach a steady input value.
- thr_lo = target - HYST, computed once when the target is latched.

FSM states: IDLE=0, FILLING=1, SETTLE=2, FULL=3, FAULT=4. Encodings 5-7 go to IDLE.

- IDLE: valve off, water_full=0, timeout count=0.
  - fill_req=1 -> FILLING.
  - On entry to FILLING, latch target from water_level_select.
- FILLING: inlet_valve_on=1.
  - Timeout counter increments per tick.
  - level_filtered >= target -> SETTLE, with settle count cleared.
  - Counter reaching FILL_TIMEOUT -> FAULT, code 01.
- SETTLE: valve off, water_full=0.
  - On each tick: level_filtered < thr_lo -> FILLING (settle count cleared, timeout count kept).
  - Otherwise settle count++. When it reaches SETTLE_TICKS -> FULL.
- FULL: water_full=1, valve off.
  - level_filtered < thr_lo (checked every cycle) -> FILLING with water_full=0 next cycle (top-up).
  - The timeout counter resumes from its held value.
- FAULT: valve off, water_full=0, fill_fault=1, fault_code held.
  - Exits to IDLE only when fill_req=0. fill_fault and fault_code clear on that transition.

Global rules:
- fill_req=0 in any non-FAULT state -> IDLE next cycle; valve off from that cycle.
- Overflow: level_filtered >= OVERFLOW_LVL in any state, including IDLE -> FAULT, code 10, next cycle.
- Overflow takes priority over timeout and over every other transition in the same cycle.
- If timeout and fill_req drop occur in the same cycle, IDLE wins (no fault).
- Outputs are registered and decoded from state; no combinational path from input to output.
- Asynchronous reset at any point returns to IDLE with the valve off immediately.

Test Plan:
1. Low fill: select=00, fill_req=1; sensor +4 per tick from 0.
   - Valve on 1 cycle after fill_req.
   - Valve off when filtered >= 64.
   - water_full=1 after 4 further ticks with filtered >= 64.
   - fault_code=00 throughout.
2. Timeout: select=10, sensor stuck at 10, fill_req held.
   - After tick 200: fill_fault=1, fault_code=01, valve=0.
   - Drop fill_req -> next cycle IDLE, fill_fault=0.
3. Overflow in IDLE: fill_req=0, sensor 250 for 4 ticks.
   - fill_fault=1, fault_code=10, state_dbg=4.
   - Repeat mid-FILLING with a concurrent timeout -> fault_code=10.
4. Settle bounce: select=01.
   - Filtered reaches 130 -> SETTLE.
   - Filtered drops to 115 at tick 2 -> FILLING, valve on, settle count restarts.
   - Filtered returns to 130 -> water_full after 4 ticks.
5. Top-up in FULL: select=01, filtered falls to 119.
   - water_full=0 and valve=1 next cycle.
   - Filtered 125 does not yet qualify as full; filtered back to 128 -> SETTLE -> water_full after 4 ticks.
6. Abort and reset mid-fill.
   - fill_req low while in FILLING -> IDLE, valve off next cycle.
   - Change water_level_select mid-fill -> target unchanged.
   - Assert reset mid-SETTLE -> all outputs 0 immediately.
